alu_in_sched: RTL

Round-robin scheduler that shares one ALU input port among `NUM_REQ` requesters. It sits between the requester clients and the ALU_in bus. It arbitrates requests, issues one-cycle `valid` strobes gated by the ALU's `ready`, and converts `rst_op` requests into timed active-low `alu_rst` pulses. It also reports which requester owns each issued operation so results can be routed back.

---
 rtl/alu_in_sched_pkg.sv | 5 +
 rtl/alu_in_rr_arbiter.sv | 32 +++
 rtl/alu_in_sched.sv | 95 +++++++++
 3 files changed

// File: rtl/alu_in_sched_pkg.sv
// alu_in_sched_pkg: shared ALU-in opcode type and scheduler state type
package alu_in_sched_pkg;
  typedef enum logic [2:0] {no_op, add_op, and_op, xor_op, mul_op, rst_op} alu_in_op_t;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESET} alu_in_sched_state_t;
endpackage

// File: rtl/alu_in_rr_arbiter.sv
// alu_in_rr_arbiter: round-robin pointer with one-hot and index grant
module alu_in_rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  input  logic                 adv,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] id,
  output logic                 any
);
  localparam int IW = $clog2(N);
  logic [IW-1:0] ptr, j;
  always_comb begin
    id = '0;
    any = 1'b0;
    j = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N);
      if (req[j]) begin
        id = j;
        any = 1'b1;
      end
    end
  end
  assign gnt = (en && any) ? N'(1) << id : '0;
  always_ff @(posedge clk)
    if (!rst) ptr <= '0;
    else if (adv) ptr <= (id == IW'(N - 1)) ? '0 : id + 1'b1;
endmodule

// File: rtl/alu_in_sched.sv
// alu_in_sched: round-robin scheduler sharing one ALU input port among requesters
module alu_in_sched
  import alu_in_sched_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int ALU_IN_OP_WIDTH = 8,
  parameter int RST_CYCLES      = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [3*NUM_REQ-1:0]               req_op,
  input  logic [ALU_IN_OP_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [ALU_IN_OP_WIDTH*NUM_REQ-1:0] req_b,
  input  logic                               ready,
  output logic                               valid,
  output logic [2:0]                         op,
  output logic [ALU_IN_OP_WIDTH-1:0]         a,
  output logic [ALU_IN_OP_WIDTH-1:0]         b,
  output logic                               alu_rst,
  output logic [$clog2(NUM_REQ)-1:0]         grant_id,
  output logic                               grant_strobe
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(RST_CYCLES + 1);
  alu_in_sched_state_t state;
  logic                wait_first, open, any, acc;
  logic [IW-1:0]       win;
  logic [CW-1:0]       cnt;
  logic [2:0]          win_op;
  assign open   = rst && ready && (state == IDLE || (state == WAIT && !wait_first));
  assign acc    = open && any;
  assign win_op = req_op[int'(win)*3 +: 3];
  alu_in_rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk (clk),
    .rst (rst),
    .req (req_valid),
    .en  (open),
    .adv (acc),
    .gnt (req_ready),
    .id  (win),
    .any (any)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      wait_first   <= 1'b0;
      cnt          <= '0;
      valid        <= 1'b0;
      op           <= no_op;
      a            <= '0;
      b            <= '0;
      alu_rst      <= 1'b0;
      grant_id     <= '0;
      grant_strobe <= 1'b0;
    end else begin
      valid        <= 1'b0;
      grant_strobe <= 1'b0;
      alu_rst      <= 1'b1;
      if (acc) begin
        grant_id     <= win;
        grant_strobe <= 1'b1;
        if (win_op == rst_op) begin
          state   <= RESET;
          alu_rst <= 1'b0;
          cnt     <= CW'(RST_CYCLES - 1);
          op      <= rst_op;
          a       <= '0;
          b       <= '0;
        end else begin
          state <= ISSUE;
          valid <= 1'b1;
          op    <= win_op;
          a     <= req_a[int'(win)*ALU_IN_OP_WIDTH +: ALU_IN_OP_WIDTH];
          b     <= req_b[int'(win)*ALU_IN_OP_WIDTH +: ALU_IN_OP_WIDTH];
        end
      end else if (state == ISSUE) begin
        state      <= WAIT;
        wait_first <= 1'b1;
      end else if (state == RESET) begin
        if (cnt == '0) begin
          state      <= WAIT;
          wait_first <= 1'b1;
        end else begin
          alu_rst <= 1'b0;
          cnt     <= cnt - 1'b1;
        end
      end else if (state == WAIT) begin
        wait_first <= 1'b0;
        if (!wait_first && ready) state <= IDLE;
      end
    end
  end
endmodule
